// File: rtl/bitrev_burst_tx.sv
// Ping-pong framer: collects N natural-order complex samples per bank and
// replays each full bank as one gap-free burst in bit-reversed index order.
module bitrev_burst_tx #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned LOG2N = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  input  logic                    di_valid,
  output logic                    di_ready,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic                    do_en,
  output logic                    do_last
);

  localparam int unsigned N = 1 << LOG2N;

  typedef enum logic {S_IDLE, S_READ} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_full;
  logic [1:0]         w_full_nxt;
  logic               r_wr_bank;
  logic               r_rd_bank;
  logic [LOG2N-1:0]   r_wr_cnt;
  logic [LOG2N-1:0]   r_rd_cnt;
  logic [LOG2N-1:0]   w_rd_addr;
  logic               w_accept;
  logic               w_wr_last;
  logic               w_rd_last;
  logic [2*WIDTH-1:0] r_mem [2*N];

  assign w_rd_last = (r_state == S_READ) && (r_rd_cnt == '1);

  // A bank whose final read issues this edge may take its first write on the
  // same edge: that write hits address 0 while the read fetches address N-1.
  assign di_ready  = !r_full[r_wr_bank] || (w_rd_last && (r_rd_bank == r_wr_bank));
  assign w_accept  = di_valid && di_ready;
  assign w_wr_last = w_accept && (r_wr_cnt == '1);

  always_comb begin
    w_rd_addr = '0;
    for (int unsigned i = 0; i < LOG2N; i++) begin
      w_rd_addr[i] = r_rd_cnt[LOG2N-1-i];
    end
  end

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_full[r_rd_bank]) w_state_nxt = S_READ;
      S_READ: if (w_rd_last && !r_full[!r_rd_bank]) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[{r_wr_bank, r_wr_cnt}] <= {di_re, di_im};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      do_re     <= '0;
      do_im     <= '0;
      do_en     <= 1'b0;
      do_last   <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (w_accept) begin
        r_wr_cnt <= r_wr_cnt + 1'b1;
        if (w_wr_last) r_wr_bank <= !r_wr_bank;
      end
      if (r_state == S_READ) begin
        {do_re, do_im} <= r_mem[{r_rd_bank, w_rd_addr}];
        do_en          <= 1'b1;
        do_last        <= w_rd_last;
        r_rd_cnt       <= r_rd_cnt + 1'b1;
        if (w_rd_last) r_rd_bank <= !r_rd_bank;
      end else begin
        do_re    <= '0;
        do_im    <= '0;
        do_en    <= 1'b0;
        do_last  <= 1'b0;
        r_rd_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitrev_burst_tx.sv
// Directed bench for bitrev_burst_tx: N=128 and N=8 builds side by side.
module tb_bitrev_burst_tx;

  localparam int W = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic signed [W-1:0] in7_re, in7_im, o7_re, o7_im;
  logic signed [W-1:0] in3_re, in3_im, o3_re, o3_im;
  logic                in7_v, rdy7, o7_en, o7_last;
  logic                in3_v, rdy3, o3_en, o3_last;

  bitrev_burst_tx #(.WIDTH(W), .LOG2N(7)) dut7 (
    .clk(clk), .rst(rst),
    .di_re(in7_re), .di_im(in7_im), .di_valid(in7_v), .di_ready(rdy7),
    .do_re(o7_re), .do_im(o7_im), .do_en(o7_en), .do_last(o7_last)
  );

  bitrev_burst_tx #(.WIDTH(W), .LOG2N(3)) dut3 (
    .clk(clk), .rst(rst),
    .di_re(in3_re), .di_im(in3_im), .di_valid(in3_v), .di_ready(rdy3),
    .do_re(o3_re), .do_im(o3_im), .do_en(o3_en), .do_last(o3_last)
  );

  int unsigned nchk = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;

  logic [2*W-1:0] accq[$];
  logic [2*W-1:0] expq[$];
  int unsigned pos7 = 0, outcnt7 = 0, run7 = 0, run7_last = 0;
  int unsigned rise7 = 0, exp_rise7 = 0, lastcnt7 = 0;
  logic        prev_en7 = 1'b0, chk_rdy7 = 1'b0;
  logic signed [W-1:0] first_re [6];
  int          t1_first [6] = '{0, 64, 32, 96, 16, 80};

  int unsigned idx3 = 0, run3 = 0, run3_last = 0;
  logic        prev_en3 = 1'b0, chk_rdy3 = 1'b0;
  int          tbl3 [16] = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expd);
    nchk++;
    assert (obs === expd) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expd);
    end
  endtask

  function automatic int unsigned br7(input int unsigned i);
    int unsigned r = 0;
    for (int b = 0; b < 7; b++) if (i[b]) r |= (1 << (6 - b));
    return r;
  endfunction

  // Accounts for the upcoming edge, then samples both DUTs at the next negedge.
  task automatic tick();
    logic [2*W-1:0] e;
    if (rst) begin
      accq.delete();
      expq.delete();
      pos7 = 0;
    end else begin
      if (in7_v && chk_rdy7) chk("rdy7_held", rdy7, 1);
      if (in3_v && chk_rdy3) chk("rdy3_held", rdy3, 1);
      if (in7_v && rdy7) begin
        accq.push_back({in7_re, in7_im});
        if (accq.size() == 128) begin
          for (int i = 0; i < 128; i++) expq.push_back(accq[br7(i)]);
          accq.delete();
          exp_rise7 = cyc + 3;
        end
      end
    end
    @(negedge clk);
    cyc++;
    if (o7_en === 1'b1) begin
      if (!prev_en7) rise7 = cyc;
      run7++;
      if (expq.size() == 0) chk("o7_unexpected_en", o7_en, 0);
      else begin
        e = expq.pop_front();
        chk("o7_re", o7_re, $signed(e[2*W-1:W]));
        chk("o7_im", o7_im, $signed(e[W-1:0]));
        chk("o7_last", o7_last, pos7 == 127);
        if (outcnt7 < 6) first_re[outcnt7] = o7_re;
        if (o7_last) lastcnt7++;
        pos7 = (pos7 + 1) % 128;
        outcnt7++;
      end
    end else begin
      if (prev_en7 && pos7 != 0) chk("o7_gap", o7_en, 1);
      if (prev_en7) run7_last = run7;
      run7 = 0;
      chk("o7_idle", {o7_en, o7_last, o7_re, o7_im}, 0);
    end
    prev_en7 = o7_en;
    if (o3_en === 1'b1) begin
      run3++;
      if (idx3 < 16) begin
        chk("o3_re", o3_re, tbl3[idx3]);
        chk("o3_im", o3_im, -tbl3[idx3]);
        chk("o3_last", o3_last, (idx3 % 8) == 7);
        idx3++;
      end else chk("o3_unexpected_en", o3_en, 0);
    end else begin
      if (prev_en3 && idx3 < 16) chk("o3_gap", o3_en, 1);
      if (prev_en3) run3_last = run3;
      run3 = 0;
      chk("o3_idle", {o3_en, o3_last, o3_re, o3_im}, 0);
    end
    prev_en3 = o3_en;
  endtask

  initial begin
    int j;
    rst = 1'b1;
    in7_v = 1'b0; in7_re = '0; in7_im = '0;
    in3_v = 1'b0; in3_re = '0; in3_im = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_rdy7", rdy7, 1);
    chk("reset_rdy3", rdy3, 1);
    chk("reset_out7", {o7_en, o7_last, o7_re, o7_im}, 0);

    // Single frame re=k, im=-k
    outcnt7 = 0; lastcnt7 = 0;
    for (int k = 0; k < 128; k++) begin
      in7_v = 1'b1; in7_re = W'(k); in7_im = W'(-k);
      tick();
    end
    in7_v = 1'b0;
    repeat (140) tick();
    chk("t1_latency", rise7, exp_rise7);
    chk("t1_run", run7_last, 128);
    chk("t1_lastcnt", lastcnt7, 1);
    for (int i = 0; i < 6; i++) chk("t1_order", first_re[i], t1_first[i]);

    // Three back-to-back frames, valid held high
    lastcnt7 = 0; chk_rdy7 = 1'b1;
    for (int k = 0; k < 384; k++) begin
      in7_v = 1'b1; in7_re = W'(k + 1000); in7_im = W'(3 * k - 500);
      tick();
    end
    in7_v = 1'b0; chk_rdy7 = 1'b0;
    repeat (140) tick();
    chk("t2_run", run7_last, 384);
    chk("t2_lastcnt", lastcnt7, 3);
    chk("t2_drained", expq.size(), 0);

    // Gapped input at ~30% duty
    j = 0;
    for (int it = 0; it < 3000 && j < 128; it++) begin
      in7_v = ($urandom_range(0, 99) < 30);
      if (in7_v) begin
        in7_re = W'(7 * j - 300); in7_im = W'(j);
        j++;
      end
      tick();
    end
    in7_v = 1'b0;
    chk("t3_sent", j, 128);
    repeat (140) tick();
    chk("t3_run", run7_last, 128);

    // Reset during a burst, then a fresh frame
    for (int k = 0; k < 128; k++) begin
      in7_v = 1'b1; in7_re = W'(500 + k); in7_im = W'(-500 - k);
      tick();
    end
    in7_v = 1'b0;
    outcnt7 = 0;
    for (int it = 0; it < 400 && outcnt7 < 50; it++) tick();
    chk("t4_reach50", outcnt7, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_out", {o7_en, o7_last, o7_re, o7_im}, 0);
    chk("t4_rst_rdy", rdy7, 1);
    for (int k = 200; k < 328; k++) begin
      in7_v = 1'b1; in7_re = W'(k); in7_im = W'(-k);
      tick();
    end
    in7_v = 1'b0;
    repeat (140) tick();
    chk("t4_run", run7_last, 128);
    chk("t4_drained", expq.size(), 0);

    // Full-scale extremes
    for (int k = 0; k < 128; k++) begin
      in7_v = 1'b1;
      in7_re = (k % 2 == 0) ? -18'sd131072 : 18'sd131071;
      in7_im = (k % 2 == 0) ? 18'sd131071 : -18'sd131072;
      tick();
    end
    in7_v = 1'b0;
    repeat (140) tick();
    chk("t5_run", run7_last, 128);

    // N=8 build, two frames back to back
    chk_rdy3 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in3_v = 1'b1; in3_re = W'(k); in3_im = W'(-k);
      tick();
    end
    in3_v = 1'b0; chk_rdy3 = 1'b0;
    repeat (30) tick();
    chk("t6_count", idx3, 16);
    chk("t6_run", run3_last, 16);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/bitrev_burst_tx.md
Name: bitrev_burst_tx

Overview:
- Ping-pong input framer that sits upstream of the 128-point FFT datapath.
- Accepts complex samples in natural order with a valid/ready handshake.
- Emits each complete N-sample frame as one gap-free burst in bit-reversed index order, framed by do_en.
- This is the producer side of the bit-reversed burst interface that the FFT reorder stage consumes.

Parameters:
- WIDTH, 18: bit width of each real and imaginary sample (signed).
- LOG2N, 7: log2 of the frame length. N = 2^LOG2N = 128 by default. Legal range is 2..10.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- di_re  input  WIDTH  input sample, real part (signed).
- di_im  input  WIDTH  input sample, imaginary part (signed).
- di_valid  input  1  input sample valid.
- di_ready  output  1  block can accept a sample. The sample transfers on any edge where di_valid && di_ready.
- do_re  output  WIDTH  output sample, real part (registered).
- do_im  output  WIDTH  output sample, imaginary part (registered).
- do_en  output  1  output sample valid. High for exactly N consecutive cycles per frame.
- do_last  output  1  high with the Nth (final) sample of each burst.

Behaviour:
- Reset (rst=1 at an edge):
  - do_re=0, do_im=0, do_en=0, do_last=0.
  - Both banks FREE; wr_bank=0, rd_bank=0; wr_cnt=0, rd_cnt=0; read FSM in IDLE.
  - Any partial or in-flight frame is discarded. Memory contents need not be cleared.
- Storage: two banks, each N x (2*WIDTH). Bank state is FREE or FULL, one flag per bank.
- Write side:
  - di_ready = (state[wr_bank]==FREE). Derived from registers only; no combinational path from di_valid.
  - On accept: mem[wr_bank][wr_cnt] <= {di_re, di_im}; wr_cnt++.
  - When wr_cnt==N-1 is accepted: state[wr_bank] <= FULL, wr_bank toggles, wr_cnt <= 0.
  - If the next bank is still FULL, di_ready stays low until that bank is freed.
- Read FSM, states IDLE and READ:
  - IDLE: if state[rd_bank]==FULL, go to READ with rd_cnt=0 on that edge. Outputs stay zero and low.
  - READ, every edge:
    - do_re/do_im <= mem[rd_bank][bitrev(rd_cnt)], where bitrev reverses the LOG2N address bits.
    - do_en <= 1; do_last <= (rd_cnt==N-1); rd_cnt++.
  - READ, on the edge issuing rd_cnt==N-1:
    - state[rd_bank] <= FREE and rd_bank toggles.
    - If the other bank is FULL on that edge, remain in READ with rd_cnt=0, so bursts run back-to-back with no idle cycle.
    - Otherwise go to IDLE.
  - Outside READ: do_en=0, do_last=0, do_re=do_im=0.
- Latency:
  - The last sample of a frame is accepted at edge E. The FSM leaves IDLE at E+1.
  - The first do_en=1 cycle follows edge E+2 and carries sample index 0.
  - Write-then-read of the same address across separate edges must return the new data.
- Throughput: sustained 1 sample/cycle.
  - With continuous di_valid, the freeing of one bank and the write-side switch onto it may coincide on one edge. This must not cause a stall, because ready is evaluated from the post-edge state.
- Simultaneous events:
  - Write completion of bank X and read completion of bank Y on the same edge are both honoured.
  - rst has priority over everything.
- Data is passed unmodified: no scaling, rounding or sign change. Full signed range is preserved.

Test Plan:
- Single frame: 128 contiguous samples with re=k, im=-k (k=0..127), then di_valid=0.
  - do_en rises 2 cycles after the last accept and stays high for 128 cycles.
  - do_re sequence is 0,64,32,96,16,80,...,127, with do_im = -do_re.
  - do_last is high only on the 128th cycle; afterwards do_en=0 and do_re=do_im=0.
- Continuous 3 frames with di_valid held high for 384 cycles.
  - di_ready never deasserts.
  - do_en is high for 384 consecutive cycles, with do_last at output cycles 128, 256 and 384.
  - Each frame is bit-reversed correctly.
- Gapped input: di_valid random at 30% duty over one frame.
  - The output burst is still 128 contiguous do_en cycles with correct bit-reversed order.
- Reset mid-burst: rst pulsed for 1 cycle at output sample 50.
  - The next cycle has do_en=0 and do=0.
  - A following fresh frame k=200..327 is emitted correctly, with no residue from the old frame.
- Extremes: samples alternate between -2^17 and 2^17-1.
  - Output values match exactly with no sign or width error.
- LOG2N=3 build, frame 0..7:
  - Output order is 0,4,2,6,1,5,3,7.
  - do_last is on the 8th cycle; two back-to-back frames have no gap.
